// File: rtl/bf_pkg.sv
// Shared widths, state encoding and payload sizing for the skid pipeline stage.
// No logic of its own; zero latency.
// Backpressure: not applicable.
package bf_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_SEL_W   = 4;
   localparam int DEF_RD_W    = 5;
   localparam int DEF_SHAMT_W = 5;

   // Occupancy of the stage: main register only, or main plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   // Packed payload layout is {op1, op2, sel, rd, shamt}.
   function automatic int payload_w(input int data_w, input int sel_w,
                                    input int rd_w, input int shamt_w);
      return 2 * data_w + sel_w + rd_w + shamt_w;
   endfunction

   localparam int PAYLOAD_W = payload_w(DEF_DATA_W, DEF_SEL_W, DEF_RD_W, DEF_SHAMT_W);

endpackage

// File: rtl/bf_payload_reg.sv
// Payload holding register with load enable and synchronous clear.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds its value whenever load is low.
module bf_payload_reg #(
   parameter int W = bf_pkg::PAYLOAD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Reset and clear both drop the content to a zero bubble; otherwise load on demand.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/bf_skid_stage.sv
// Pipeline register between two stages with a 2-entry skid buffer and stall counter.
// Latency: 1 cycle input to output when empty; 1 item/cycle while out_ready is high.
// Backpressure: in_ready is registered and drops only when both entries are occupied.
module bf_skid_stage #(
   parameter int DATA_W  = bf_pkg::DEF_DATA_W,
   parameter int SEL_W   = bf_pkg::DEF_SEL_W,
   parameter int RD_W    = bf_pkg::DEF_RD_W,
   parameter int SHAMT_W = bf_pkg::DEF_SHAMT_W,
   parameter int CNT_W   = 16
) (
   input  logic               clk_bf_skid_stage,
   input  logic               rst_bf_skid_stage,
   input  logic               flush_in,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  dIn1,
   input  logic [DATA_W-1:0]  dIn2,
   input  logic [SEL_W-1:0]   dIn_sel,
   input  logic [RD_W-1:0]    dIn_rd,
   input  logic [SHAMT_W-1:0] dIn_shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  data1_out,
   output logic [DATA_W-1:0]  data2_out,
   output logic [SEL_W-1:0]   sel_out,
   output logic [RD_W-1:0]    rd_out,
   output logic [SHAMT_W-1:0] shamt_out,
   output logic [CNT_W-1:0]   stall_cnt
);
   import bf_pkg::*;

   localparam int PW = payload_w(DATA_W, SEL_W, RD_W, SHAMT_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t        state;
   state_t        state_nxt;
   logic          accept;
   logic          emit;
   logic          load_main;
   logic          load_skid;
   logic          main_from_skid;
   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_d;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;
   assign in_pl  = {dIn1, dIn2, dIn_sel, dIn_rd, dIn_shamt};
   assign main_d = main_from_skid ? skid_q : in_pl;

   // Next occupancy and which holding register captures what this cycle.
   always_comb begin
      state_nxt      = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      case (state)
         EMPTY: begin
            if (accept) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && emit) begin
               load_main = 1'b1;
            end else if (accept) begin
               state_nxt = TWO;
               load_skid = 1'b1;
            end else if (emit) begin
               state_nxt = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so the only event is the head leaving.
            if (emit) begin
               state_nxt      = ONE;
               load_main      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // Occupancy register; flush turns the stage into a bubble.
   always_ff @(posedge clk_bf_skid_stage) begin
      if (rst_bf_skid_stage || flush_in) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake outputs are registered copies of the next occupancy.
   always_ff @(posedge clk_bf_skid_stage) begin
      if (rst_bf_skid_stage || flush_in) begin
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         out_valid <= (state_nxt != EMPTY);
         in_ready  <= (state_nxt != TWO);
      end
   end

   // Saturating count of cycles where a valid output is held back; only reset clears it.
   always_ff @(posedge clk_bf_skid_stage) begin
      if (rst_bf_skid_stage) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   bf_payload_reg #(.W(PW)) u_main (
      .clk  (clk_bf_skid_stage),
      .rst  (rst_bf_skid_stage),
      .clr  (flush_in),
      .load (load_main),
      .d    (main_d),
      .q    (main_q)
   );

   bf_payload_reg #(.W(PW)) u_skid (
      .clk  (clk_bf_skid_stage),
      .rst  (rst_bf_skid_stage),
      .clr  (flush_in),
      .load (load_skid),
      .d    (in_pl),
      .q    (skid_q)
   );

   assign {data1_out, data2_out, sel_out, rd_out, shamt_out} = main_q;

endmodule

// File: doc/bf_skid_stage.md
Name: bf_skid_stage

Overview:
- Parametrised successor to the decode/execute pipeline buffer. Registers the ALU operands, ALU select, destination register and shift amount between two pipeline stages.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered in_ready), synchronous flush to a bubble, and a saturating backpressure counter.
- Instanced between any two MIPS pipeline stages (ID/EX first).

Parameters:
- DATA_W, 32, width of each operand field
- SEL_W, 4, ALU select width
- RD_W, 5, destination register index width
- SHAMT_W, 5, shift amount width
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk_bf_skid_stage  in  1  clock, rising edge
- rst_bf_skid_stage  in  1  synchronous active-high reset
- flush_in  in  1  discard all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept (registered)
- dIn1, dIn2  in  DATA_W  operands
- dIn_sel  in  SEL_W  ALU select
- dIn_rd  in  RD_W  destination register
- dIn_shamt  in  SHAMT_W  shift amount
- out_valid  out  1  output payload valid
- out_ready  in  1  downstream accepts
- data1_out, data2_out  out  DATA_W  registered operands
- sel_out  out  SEL_W
- rd_out  out  RD_W
- shamt_out  out  SHAMT_W
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk_bf_skid_stage; reset port is rst_bf_skid_stage.
- Priority at each rising edge: reset > flush > normal operation.
- Reset values:
  - out_valid=0, in_ready=1, stall_cnt=0.
  - All payload outputs 0; skid register 0; state EMPTY.
  - in_valid during a reset cycle is ignored.
- Transfer definitions: accept = in_valid & in_ready; emit = out_valid & out_ready.
- States (occupancy):
  - EMPTY: main invalid.
  - ONE: main valid, skid empty.
  - TWO: main and skid valid.
- Transitions:
  - EMPTY: accept -> ONE, main<=input. Otherwise stay.
  - ONE:
    - accept & emit -> ONE, main<=input.
    - accept & !emit -> TWO, skid<=input.
    - !accept & emit -> EMPTY.
    - Neither -> stay.
  - TWO: emit -> ONE, main<=skid. Otherwise stay. in_ready is 0 in TWO, so no accept is possible.
- Output and ready derivation:
  - out_valid = (state != EMPTY), driven from a register.
  - Payload outputs always show the main register.
  - in_ready register loads (next_state != TWO).
- Latency: 1 cycle input->output when EMPTY. Throughput is 1 item/cycle while out_ready=1.
- Ordering: strictly FIFO. The skid entry is never emitted before main.
- Payload hold: while out_valid=1 and out_ready=0, payload outputs are stable.
- Payload in EMPTY: payload outputs keep their last value (don't-care), except after reset or flush, where they are 0.
- Flush:
  - Next state EMPTY; out_valid=0; in_ready=1.
  - Main and skid payloads zeroed (bubble/NOP).
  - Any accept or emit in the flush cycle is discarded; upstream must re-present.
  - stall_cnt unaffected.
- stall_cnt:
  - +1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.
- Simultaneous events:
  - Accept and emit in ONE: pass-through, no occupancy change.
  - Flush with reset: reset wins (same result plus stall_cnt=0).
- Reset mid-operation: all held entries dropped, no partial output.

Decomposition:
- Package bf_pkg:
  - Default widths: DATA_W=32, SEL_W=4, RD_W=5, SHAMT_W=5.
  - Packed payload width PAYLOAD_W = 2*DATA_W+SEL_W+RD_W+SHAMT_W.
  - State encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- Sub-module bf_payload_reg:
  - Parametrised PAYLOAD_W register with load enable and synchronous clear.
  - Instanced twice: main and skid.
- Top-level contents: FSM, ready/valid logic, counter.

Test Plan:
- Reset release, in_valid=1, dIn1=0x11, dIn2=0x22, dIn_sel=4'h2, dIn_rd=5'd9, dIn_shamt=5'd3, out_ready=1 -> next cycle out_valid=1 with identical fields; in_ready stays 1.
- Stream 0x1..0x8 in dIn1 on consecutive cycles, out_ready=1 -> outputs 0x1..0x8 on consecutive cycles, no gaps, stall_cnt=0.
- Accept A, B while out_ready=0 -> in_ready=0 after B, data1_out=A held; stall_cnt increments each cycle. Raise out_ready -> A then B emitted in order, in_ready back to 1.
- State TWO, assert flush_in with out_ready=1 -> next cycle out_valid=0, all payload outputs 0, in_ready=1, nothing emitted. stall_cnt retains its pre-flush value.
- CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
- Assert reset while in TWO -> next cycle out_valid=0, in_ready=1, stall_cnt=0, payload 0; first post-reset accept emerges 1 cycle later.
